roulette_bet_engine: RTL and testbench

Parametrised, fully synchronous roulette betting engine. It supports three bet modes: parity (even/odd), half (low/high) and exact number. Payouts, stake, start balance and win target are all configurable. It sits between the switch/key input layer and the HEX/LED display drivers. It consumes a random number from the shared LFSR and a player guess, and maintains the player balance.

---
 rtl/roulette_bet_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_roulette_bet_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/roulette_bet_engine.sv
// roulette_bet_engine
//   Roulette betting engine with three bet modes (parity, half, exact).
//   It takes a wheel number from the shared LFSR and a player guess, and
//   keeps the player balance. The game ends in WON or LOST.
//
//   Spin pipeline:
//     edge E0 : the spin rising edge is seen in PLAY; mode/guess/randnum are
//               latched into the operand registers and vld_p1 is raised.
//     edge E1 : the latched bet is checked and resolved; balance, last_win
//               and the result_valid/bad_bet pulses are registered.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset (highest priority)
//   restart      synchronous game restart, active-high level
//   spin         spin request, acted on at its rising edge
//   mode         00 parity, 01 half, 10 exact, 11 illegal
//   guess        parity: bit0=1 even; half: bit0=1 high; exact: number
//   randnum      wheel number, sampled at the spin edge
//   balance      current player balance
//   state        00 IDLE, 01 PLAY, 10 LOST, 11 WON
//   result_valid one-cycle pulse when a legal spin is resolved
//   last_win     outcome of the most recent resolved spin
//   bad_bet      one-cycle pulse when a spin is rejected
//   won / lost   decodes of the registered state
module roulette_bet_engine #(
  parameter int BAL_W      = 8,
  parameter int NUM_W      = 6,
  parameter int NUM_MAX    = 36,
  parameter int START_BAL  = 10,
  parameter int WIN_BAL    = 20,
  parameter int STAKE      = 1,
  parameter int PAY_PARITY = 2,
  parameter int PAY_HALF   = 2,
  parameter int PAY_EXACT  = 35
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             spin,
  input  logic [1:0]       mode,
  input  logic [NUM_W-1:0] guess,
  input  logic [NUM_W-1:0] randnum,
  output logic [BAL_W-1:0] balance,
  output logic [1:0]       state,
  output logic             result_valid,
  output logic             last_win,
  output logic             bad_bet,
  output logic             won,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    LOST = 2'b10,
    WON  = 2'b11
  } state_t;

  localparam int             BAL_MAX_I = (1 << BAL_W) - 1;
  localparam logic [BAL_W:0] BAL_MAX   = (BAL_W+1)'(BAL_MAX_I);

  // Amounts wider than the balance register are clamped first so that the
  // BAL_W+1 bit arithmetic never sees a truncated constant.
  function automatic logic [BAL_W:0] clamp_amt(input int v);
    if (v > BAL_MAX_I) return BAL_MAX;
    return (BAL_W+1)'(v);
  endfunction

  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] b,
                                               input logic [BAL_W:0]   amt);
    logic [BAL_W:0] s;
    s = {1'b0, b} + amt;
    if (s > BAL_MAX) return BAL_MAX[BAL_W-1:0];
    return s[BAL_W-1:0];
  endfunction

  function automatic logic [BAL_W-1:0] floor_sub(input logic [BAL_W-1:0] b,
                                                 input logic [BAL_W:0]   amt);
    logic [BAL_W:0] s;
    if ({1'b0, b} <= amt) return '0;
    s = {1'b0, b} - amt;
    return s[BAL_W-1:0];
  endfunction

  localparam logic [BAL_W:0]   PAY_PARITY_C = clamp_amt(PAY_PARITY);
  localparam logic [BAL_W:0]   PAY_HALF_C   = clamp_amt(PAY_HALF);
  localparam logic [BAL_W:0]   PAY_EXACT_C  = clamp_amt(PAY_EXACT);
  localparam logic [BAL_W:0]   STAKE_C      = clamp_amt(STAKE);
  localparam logic [BAL_W-1:0] START_BAL_C  = BAL_W'(START_BAL);

  state_t           state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             result_valid_q, result_valid_d;
  logic             last_win_q, last_win_d;
  logic             bad_bet_q, bad_bet_d;
  logic             spin_q, spin_d;
  logic             vld_p1_q, vld_p1_d;
  logic [1:0]       mode_p1_q, mode_p1_d;
  logic [NUM_W-1:0] guess_p1_q, guess_p1_d;
  logic [NUM_W-1:0] rand_p1_q, rand_p1_d;

  logic             spin_edge;
  logic             illegal_p1;
  logic             win_p1;
  logic             rand_high_p1;
  logic [BAL_W:0]   pay_p1;
  logic [BAL_W-1:0] bal_upd_p1;

  assign spin_edge = spin & ~spin_q;

  // ---- stage p1: evaluate the latched bet ----
  always_comb begin
    illegal_p1   = (mode_p1_q == 2'b11) ||
                   (int'(rand_p1_q) > NUM_MAX) ||
                   ((mode_p1_q == 2'b10) && (int'(guess_p1_q) > NUM_MAX));
    rand_high_p1 = int'(rand_p1_q) > (NUM_MAX / 2);
    win_p1       = 1'b0;
    pay_p1       = PAY_PARITY_C;
    case (mode_p1_q)
      2'b00: begin
        // guess bit0 = 1 means even, so a win needs randnum bit0 = 0
        win_p1 = (rand_p1_q != '0) && (rand_p1_q[0] == ~guess_p1_q[0]);
        pay_p1 = PAY_PARITY_C;
      end
      2'b01: begin
        win_p1 = (rand_p1_q != '0) && (rand_high_p1 == guess_p1_q[0]);
        pay_p1 = PAY_HALF_C;
      end
      2'b10: begin
        win_p1 = (rand_p1_q == guess_p1_q);
        pay_p1 = PAY_EXACT_C;
      end
      default: begin
        win_p1 = 1'b0;
        pay_p1 = PAY_PARITY_C;
      end
    endcase
    bal_upd_p1 = win_p1 ? sat_add(balance_q, pay_p1)
                        : floor_sub(balance_q, STAKE_C);
  end

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    result_valid_d = 1'b0;
    bad_bet_d      = 1'b0;
    last_win_d     = last_win_q;
    spin_d         = spin;
    vld_p1_d       = 1'b0;
    mode_p1_d      = mode_p1_q;
    guess_p1_d     = guess_p1_q;
    rand_p1_d      = rand_p1_q;

    case (state_q)
      IDLE: begin
        balance_d = START_BAL_C;
        // The entering edge only starts the game; no bet is taken from it.
        if (spin_edge) state_d = PLAY;
      end
      PLAY: begin
        if (vld_p1_q) begin
          if (illegal_p1) begin
            bad_bet_d = 1'b1;
          end else begin
            result_valid_d = 1'b1;
            last_win_d     = win_p1;
            balance_d      = bal_upd_p1;
            if (int'(bal_upd_p1) >= WIN_BAL) state_d = WON;
            else if (bal_upd_p1 == '0)       state_d = LOST;
          end
        end
        // A new spin is accepted alongside a resolution unless that
        // resolution has just ended the game.
        if (spin_edge && (state_d == PLAY)) begin
          vld_p1_d   = 1'b1;
          mode_p1_d  = mode;
          guess_p1_d = guess;
          rand_p1_d  = randnum;
        end
      end
      default: begin
        // WON / LOST: everything frozen until restart or reset
      end
    endcase

    if (restart) begin
      state_d        = IDLE;
      balance_d      = START_BAL_C;
      result_valid_d = 1'b0;
      bad_bet_d      = 1'b0;
      last_win_d     = last_win_q;
      vld_p1_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      balance_q      <= START_BAL_C;
      result_valid_q <= 1'b0;
      last_win_q     <= 1'b0;
      bad_bet_q      <= 1'b0;
      spin_q         <= 1'b0;
      vld_p1_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      result_valid_q <= result_valid_d;
      last_win_q     <= last_win_d;
      bad_bet_q      <= bad_bet_d;
      spin_q         <= spin_d;
      vld_p1_q       <= vld_p1_d;
    end
  end

  // Operand registers carry data only and are qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    mode_p1_q  <= mode_p1_d;
    guess_p1_q <= guess_p1_d;
    rand_p1_q  <= rand_p1_d;
  end

  assign balance      = balance_q;
  assign state        = state_q;
  assign result_valid = result_valid_q;
  assign last_win     = last_win_q;
  assign bad_bet      = bad_bet_q;
  assign won          = (state_q == WON);
  assign lost         = (state_q == LOST);

endmodule

// File: tb/tb_roulette_bet_engine.sv
module tb_roulette_bet_engine;

  logic       clk = 1'b0;
  logic       reset_n, restart, spin;
  logic [1:0] mode;
  logic [5:0] guess, randnum;
  logic [7:0] balance;
  logic [1:0] state;
  logic       result_valid, last_win, bad_bet, won, lost;

  // second instance with a 4-bit balance for the saturation corner
  logic       s_reset_n, s_restart, s_spin;
  logic [1:0] s_mode;
  logic [5:0] s_guess, s_randnum;
  logic [3:0] s_balance;
  logic [1:0] s_state;
  logic       s_result_valid, s_last_win, s_bad_bet, s_won, s_lost;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  roulette_bet_engine dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .spin(spin),
    .mode(mode), .guess(guess), .randnum(randnum),
    .balance(balance), .state(state), .result_valid(result_valid),
    .last_win(last_win), .bad_bet(bad_bet), .won(won), .lost(lost)
  );

  roulette_bet_engine #(.BAL_W(4)) dut_s (
    .clk(clk), .reset_n(s_reset_n), .restart(s_restart), .spin(s_spin),
    .mode(s_mode), .guess(s_guess), .randnum(s_randnum),
    .balance(s_balance), .state(s_state), .result_valid(s_result_valid),
    .last_win(s_last_win), .bad_bet(s_bad_bet), .won(s_won), .lost(s_lost)
  );

  typedef struct {
    logic [1:0] m;
    logic [5:0] g;
    logic [5:0] r;
    logic       rv;
    logic       bb;
    logic       lw;
    logic [7:0] bal;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; restart = 1'b0; spin = 1'b0;
    mode = 2'd0; guess = 6'd0; randnum = 6'd0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // Leave IDLE; the entering edge must not produce a result.
  task automatic enter_play(input string tag);
    spin = 1'b1;
    tick();
    chk({tag, " enter rv"}, 32'(result_valid), 32'd0);
    spin = 1'b0;
    tick();
    chk({tag, " enter rv2"}, 32'(result_valid), 32'd0);
    chk({tag, " enter state"}, 32'(state), 32'd1);
  endtask

  // One spin; returns sampled just after the resolving edge.
  task automatic spin_bet(input logic [1:0] m, input logic [5:0] g, input logic [5:0] r);
    mode = m; guess = g; randnum = r; spin = 1'b1;
    tick();
    spin = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] exp_bal;

    //                m     g      r      rv    bb    lw    bal    st
    vecs[0]  = '{2'd0, 6'd1,  6'd8,  1'b1, 1'b0, 1'b1, 8'd12, 2'd1};
    vecs[1]  = '{2'd0, 6'd1,  6'd0,  1'b1, 1'b0, 1'b0, 8'd11, 2'd1};
    vecs[2]  = '{2'd0, 6'd0,  6'd7,  1'b1, 1'b0, 1'b1, 8'd13, 2'd1};
    vecs[3]  = '{2'd1, 6'd1,  6'd30, 1'b1, 1'b0, 1'b1, 8'd15, 2'd1};
    vecs[4]  = '{2'd1, 6'd0,  6'd18, 1'b1, 1'b0, 1'b1, 8'd17, 2'd1};
    vecs[5]  = '{2'd1, 6'd0,  6'd19, 1'b1, 1'b0, 1'b0, 8'd16, 2'd1};
    vecs[6]  = '{2'd1, 6'd1,  6'd0,  1'b1, 1'b0, 1'b0, 8'd15, 2'd1};
    vecs[7]  = '{2'd3, 6'd0,  6'd5,  1'b0, 1'b1, 1'b0, 8'd15, 2'd1};
    vecs[8]  = '{2'd0, 6'd1,  6'd40, 1'b0, 1'b1, 1'b0, 8'd15, 2'd1};
    vecs[9]  = '{2'd0, 6'd1,  6'd37, 1'b0, 1'b1, 1'b0, 8'd15, 2'd1};
    vecs[10] = '{2'd2, 6'd37, 6'd5,  1'b0, 1'b1, 1'b0, 8'd15, 2'd1};
    vecs[11] = '{2'd2, 6'd5,  6'd6,  1'b1, 1'b0, 1'b0, 8'd14, 2'd1};
    vecs[12] = '{2'd2, 6'd36, 6'd36, 1'b1, 1'b0, 1'b1, 8'd49, 2'd3};
    vecs[13] = '{2'd0, 6'd1,  6'd8,  1'b0, 1'b0, 1'b1, 8'd49, 2'd3};

    s_reset_n = 1'b0; s_restart = 1'b0; s_spin = 1'b0;
    s_mode = 2'd0; s_guess = 6'd0; s_randnum = 6'd0;

    // reset state
    do_reset();
    s_reset_n = 1'b1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset balance", 32'(balance), 32'd10);
    chk("reset rv", 32'(result_valid), 32'd0);
    chk("reset last_win", 32'(last_win), 32'd0);
    chk("reset bad_bet", 32'(bad_bet), 32'd0);
    chk("reset won/lost", 32'({won, lost}), 32'd0);

    // table of directed bets from balance 10
    enter_play("tbl");
    chk("tbl enter balance", 32'(balance), 32'd10);
    for (int i = 0; i < 14; i++) begin
      spin_bet(vecs[i].m, vecs[i].g, vecs[i].r);
      chk($sformatf("vec%0d rv", i), 32'(result_valid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d bad_bet", i), 32'(bad_bet), 32'(vecs[i].bb));
      chk($sformatf("vec%0d last_win", i), 32'(last_win), 32'(vecs[i].lw));
      chk($sformatf("vec%0d balance", i), 32'(balance), 32'(vecs[i].bal));
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d won", i), 32'(won), 32'(vecs[i].st == 2'd3));
      tick();
      chk($sformatf("vec%0d pulse end", i), 32'({result_valid, bad_bet}), 32'd0);
    end

    // restart from WON keeps last_win
    do_restart();
    chk("restart state", 32'(state), 32'd0);
    chk("restart balance", 32'(balance), 32'd10);
    chk("restart last_win held", 32'(last_win), 32'd1);

    // exact hit to WON, then frozen
    enter_play("exact");
    spin_bet(2'd2, 6'd17, 6'd17);
    chk("exact balance", 32'(balance), 32'd45);
    chk("exact state", 32'(state), 32'd3);
    chk("exact won", 32'(won), 32'd1);
    spin_bet(2'd0, 6'd1, 6'd8);
    chk("won frozen balance", 32'(balance), 32'd45);
    chk("won frozen rv", 32'(result_valid), 32'd0);
    do_restart();
    chk("exact restart state", 32'(state), 32'd0);
    chk("exact restart balance", 32'(balance), 32'd10);

    // ten losing half bets down to LOST
    enter_play("lose");
    for (int i = 0; i < 10; i++) begin
      spin_bet(2'd1, 6'd1, 6'd3);
      exp_bal = 8'(9 - i);
      chk($sformatf("lose%0d balance", i), 32'(balance), 32'(exp_bal));
      chk($sformatf("lose%0d rv", i), 32'(result_valid), 32'd1);
      chk($sformatf("lose%0d state", i), 32'(state), (i == 9) ? 32'd2 : 32'd1);
    end
    chk("lost flag", 32'(lost), 32'd1);
    spin_bet(2'd1, 6'd1, 6'd3);
    chk("lost ignored rv", 32'(result_valid), 32'd0);
    chk("lost ignored balance", 32'(balance), 32'd0);
    chk("lost ignored state", 32'(state), 32'd2);
    do_restart();

    // spin held high for five cycles: one evaluation
    enter_play("hold");
    mode = 2'd0; guess = 6'd1; randnum = 6'd8; spin = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (result_valid) cnt++; end
    spin = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (result_valid) cnt++; end
    chk("hold eval count", 32'(cnt), 32'd1);
    chk("hold balance", 32'(balance), 32'd12);

    // restart together with a spin edge
    spin = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart+spin state", 32'(state), 32'd0);
    chk("restart+spin balance", 32'(balance), 32'd10);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (result_valid || bad_bet) cnt++; end
    spin = 1'b0;
    tick();
    chk("restart+spin no eval", 32'(cnt), 32'd0);
    chk("restart+spin idle", 32'(state), 32'd0);

    // reset one cycle after a spin edge
    enter_play("rst");
    mode = 2'd1; guess = 6'd1; randnum = 6'd3; spin = 1'b1;
    tick();
    reset_n = 1'b0; spin = 1'b0;
    tick();
    chk("mid reset rv", 32'(result_valid), 32'd0);
    chk("mid reset balance", 32'(balance), 32'd10);
    chk("mid reset state", 32'(state), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (result_valid) cnt++; end
    chk("mid reset no result", 32'(cnt), 32'd0);
    chk("mid reset balance later", 32'(balance), 32'd10);

    // back-to-back spins, second edge right after the first resolves
    enter_play("b2b");
    spin_bet(2'd0, 6'd1, 6'd8);
    chk("b2b first rv", 32'(result_valid), 32'd1);
    chk("b2b first balance", 32'(balance), 32'd12);
    spin_bet(2'd0, 6'd1, 6'd0);
    chk("b2b second rv", 32'(result_valid), 32'd1);
    chk("b2b second balance", 32'(balance), 32'd11);
    chk("b2b second last_win", 32'(last_win), 32'd0);

    // 4-bit balance saturates at 15
    s_spin = 1'b1; tick(); s_spin = 1'b0; tick();
    chk("sat enter state", 32'(s_state), 32'd1);
    s_mode = 2'd2; s_guess = 6'd17; s_randnum = 6'd17; s_spin = 1'b1;
    tick(); s_spin = 1'b0; tick();
    chk("sat rv", 32'(s_result_valid), 32'd1);
    chk("sat balance", 32'(s_balance), 32'd15);
    chk("sat state", 32'(s_state), 32'd1);
    s_spin = 1'b1; tick(); s_spin = 1'b0; tick();
    chk("sat again balance", 32'(s_balance), 32'd15);
    s_randnum = 6'd3; s_spin = 1'b1; tick(); s_spin = 1'b0; tick();
    chk("sat loss balance", 32'(s_balance), 32'd14);
    chk("sat loss last_win", 32'(s_last_win), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
